// File: rtl/en_period_monitor_pkg.sv
// Shared definitions for the enable-period monitor: FSM encoding and the
// width helper used to size counters from parameters.
package en_period_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  localparam int ERR_CNT_W = 8;

  // Bits needed to hold values 0 .. value-1 (so clog2(N+1) holds 0..N).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/en_period_monitor_if.sv
// Observation bundle between the strobe source / status consumer and the
// period monitor.
interface en_period_monitor_if
  import en_period_monitor_pkg::*;
#(
  parameter int CW = 6
);
  logic                 en_in;
  logic                 clear;
  logic                 locked;
  logic                 err_pulse;
  logic [CW-1:0]        period;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output en_in, clear,
    input  locked, err_pulse, period, err_cnt
  );

  modport slave (
    input  en_in, clear,
    output locked, err_pulse, period, err_cnt
  );
endinterface

// File: rtl/en_period_monitor_interval_counter.sv
// Cycles-since-last-strobe counter: reloads to 1 on a strobe and otherwise
// climbs until it sticks at TMO.
module en_interval_counter
  import en_period_monitor_pkg::*;
#(
  parameter  int TMO = 32,
  localparam int CW  = clog2(TMO + 1)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en_in,
  output logic [CW-1:0] cnt
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CW'(TMO)) return v;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst)        cnt <= '0;
    else if (en_in) cnt <= CW'(1);
    else            cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/en_period_monitor.sv
// Verifies that en_in strobes every DIV cycles: locks after LOCK_CNT exact
// intervals, flags each loss of lock and keeps a saturating error count.
module en_period_monitor
  import en_period_monitor_pkg::*;
#(
  parameter int DIV      = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic               clk_in,
  input  logic               rst,
  en_period_monitor_if.slave mon
);

  localparam int TMO = 2 * DIV;
  localparam int CW  = clog2(TMO + 1);
  localparam int GW  = clog2(LOCK_CNT + 1);

  logic [CW-1:0]        cnt;
  mon_state_e           state_q, state_d;
  logic [GW-1:0]        good_q, good_d;
  logic [CW-1:0]        period_q, period_d;
  logic                 err_d;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  en_interval_counter #(.TMO(TMO)) u_interval (
    .clk_in (clk_in),
    .rst    (rst),
    .en_in  (mon.en_in),
    .cnt    (cnt)
  );

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mon.en_in) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (mon.en_in) begin
          period_d = cnt;
          if (cnt == CW'(DIV)) begin
            if (good_q == GW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d  = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end else if (cnt == CW'(TMO)) begin
          state_d = IDLE;
          good_d  = '0;
        end
      end
      LOCKED: begin
        // Any strobe off the exact period loses lock; the late check only
        // applies when no strobe arrives, so en_in wins a tie at DIV+1.
        if (mon.en_in) begin
          period_d = cnt;
          if (cnt != CW'(DIV)) begin
            err_d   = 1'b1;
            state_d = MEASURE;
            good_d  = '0;
          end
        end else if (cnt == CW'(DIV + 1)) begin
          err_d   = 1'b1;
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      good_q      <= '0;
      period_q    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      period_q    <= period_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_d;
      if (mon.clear)  err_cnt_q <= '0;
      else if (err_d) err_cnt_q <= sat_inc_err(err_cnt_q);
    end
  end

  assign mon.locked    = locked_q;
  assign mon.err_pulse = err_pulse_q;
  assign mon.period    = period_q;
  assign mon.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_en_period_monitor.sv
// Self-checking bench for en_period_monitor: directed scenarios against fixed
// expectations plus randomized traffic against a timestamp-based model.
module tb_en_period_monitor;
  import en_period_monitor_pkg::*;

  localparam int DIV = 16;
  localparam int LOCK_CNT = 4;
  localparam int TMO = 2 * DIV;
  localparam int CW = clog2(TMO + 1);

  logic clk_in;
  logic rst;
  logic rst1;
  int checks;
  int errors;

  en_period_monitor_if #(.CW(CW)) mif ();
  en_period_monitor_if #(.CW(CW)) mif1 ();

  en_period_monitor #(.DIV(DIV), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .mon    (mif)
  );

  en_period_monitor #(.DIV(DIV), .LOCK_CNT(1)) dut1 (
    .clk_in (clk_in),
    .rst    (rst1),
    .mon    (mif1)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: interval is the distance in cycles to the last strobe
  // (capped at TMO), evaluated with the rules for each monitor mode.
  longint now_cyc;
  longint last_strobe;
  int m_mode;       // 0 idle, 1 measuring, 2 locked
  int m_good;
  int m_locked;
  int m_err;
  int m_period;
  int m_errcnt;

  task automatic model_step(input logic en, input logic clr, input logic r);
    longint iv;
    if (r) begin
      m_mode = 0; m_good = 0; m_locked = 0; m_err = 0;
      m_period = 0; m_errcnt = 0;
      last_strobe = now_cyc + 1;
      now_cyc++;
      return;
    end
    iv = now_cyc - last_strobe;
    if (iv > TMO) iv = TMO;
    m_err = 0;
    if (en) begin
      if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else begin
        m_period = int'(iv);
        if (m_mode == 1) begin
          if (iv == DIV) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_mode = 2; m_good = 0; end
          end else m_good = 0;
        end else if (iv != DIV) begin
          m_err = 1; m_mode = 1; m_good = 0;
        end
      end
      last_strobe = now_cyc;
    end else if (m_mode == 2 && iv == DIV + 1) begin
      m_err = 1; m_mode = 1; m_good = 0;
    end else if (m_mode == 1 && iv == TMO) begin
      m_mode = 0; m_good = 0;
    end
    m_locked = (m_mode == 2) ? 1 : 0;
    if (clr) m_errcnt = 0;
    else if (m_err != 0 && m_errcnt < 255) m_errcnt++;
    now_cyc++;
  endtask

  task automatic tick(input logic en, input logic clr, input logic r);
    mif.en_in = en;
    mif.clear = clr;
    rst = r;
    model_step(en, clr, r);
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe_after(input int n, input logic clr);
    repeat (n - 1) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, clr, 1'b0);
  endtask

  task automatic lock_up();
    tick(1'b1, 1'b0, 1'b0);
    repeat (LOCK_CNT) strobe_after(DIV, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", mif.locked); end
    checks++; if (mif.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %0b expected 0", mif.err_pulse); end
    checks++; if (mif.period !== '0) begin errors++; $display("FAIL reset_period: got %0d expected 0", mif.period); end
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", mif.err_cnt); end
  endtask

  task automatic test_lock();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    repeat (LOCK_CNT - 1) strobe_after(DIV, 1'b0);
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL lock_early_rise: got %0b expected 0", mif.locked); end
    strobe_after(DIV, 1'b0);
    checks++; if (mif.locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %0b expected 1", mif.locked); end
    checks++; if (mif.period !== CW'(DIV)) begin errors++; $display("FAIL lock_period: got %0d expected %0d", mif.period, DIV); end
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err_cnt: got %0d expected 0", mif.err_cnt); end
  endtask

  task automatic test_early();
    strobe_after(12, 1'b0);
    checks++; if (mif.err_pulse !== 1'b1) begin errors++; $display("FAIL early_err_pulse: got %0b expected 1", mif.err_pulse); end
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL early_locked: got %0b expected 0", mif.locked); end
    checks++; if (mif.period !== CW'(12)) begin errors++; $display("FAIL early_period: got %0d expected 12", mif.period); end
    checks++; if (mif.err_cnt !== 8'd1) begin errors++; $display("FAIL early_err_cnt: got %0d expected 1", mif.err_cnt); end
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (mif.err_pulse !== 1'b0) begin errors++; $display("FAIL early_pulse_width: got %0b expected 0", mif.err_pulse); end
  endtask

  task automatic test_late();
    tick(1'b0, 1'b0, 1'b1);
    lock_up();
    repeat (DIV) tick(1'b0, 1'b0, 1'b0);
    checks++; if (mif.locked !== 1'b1 || mif.err_pulse !== 1'b0) begin errors++; $display("FAIL late_too_soon: got locked=%0b err=%0b expected 1/0", mif.locked, mif.err_pulse); end
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (mif.err_pulse !== 1'b1) begin errors++; $display("FAIL late_err_pulse: got %0b expected 1", mif.err_pulse); end
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL late_locked: got %0b expected 0", mif.locked); end
    repeat (TMO - DIV - 1) tick(1'b0, 1'b0, 1'b0);
    // Monitor is now idle: this strobe must not update period.
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (mif.period !== CW'(DIV)) begin errors++; $display("FAIL late_idle_period: got %0d expected %0d", mif.period, DIV); end
    checks++; if (mif.err_cnt !== 8'd1) begin errors++; $display("FAIL late_err_cnt: got %0d expected 1", mif.err_cnt); end
  endtask

  task automatic test_err_saturation();
    tick(1'b0, 1'b0, 1'b1);
    lock_up();
    for (int i = 1; i <= 300; i++) begin
      strobe_after(DIV - 1, 1'b0);
      if (i == 1) begin
        checks++; if (mif.err_cnt !== 8'd1) begin errors++; $display("FAIL sat_first: got %0d expected 1", mif.err_cnt); end
      end
      if (i == 255 || i == 300) begin
        checks++; if (mif.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt_%0d: got %0d expected 255", i, mif.err_cnt); end
      end
      repeat (LOCK_CNT) strobe_after(DIV, 1'b0);
    end
    strobe_after(DIV - 1, 1'b1);
    checks++; if (mif.err_pulse !== 1'b1) begin errors++; $display("FAIL clear_err_pulse: got %0b expected 1", mif.err_pulse); end
    checks++; if (mif.err_cnt !== 8'd0) begin errors++; $display("FAIL clear_wins: got %0d expected 0", mif.err_cnt); end
  endtask

  task automatic test_reset_mid_lock();
    tick(1'b0, 1'b0, 1'b1);
    lock_up();
    strobe_after(DIV - 2, 1'b0);
    lock_up();
    checks++; if (mif.locked !== 1'b1) begin errors++; $display("FAIL mid_pre_lock: got %0b expected 1", mif.locked); end
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (mif.locked !== 1'b0 || mif.err_pulse !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got locked=%0b err=%0b expected 0/0", mif.locked, mif.err_pulse); end
    checks++; if (mif.period !== '0 || mif.err_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_data: got period=%0d err_cnt=%0d expected 0/0", mif.period, mif.err_cnt); end
    lock_up();
    checks++; if (mif.locked !== 1'b1) begin errors++; $display("FAIL mid_relock: got %0b expected 1", mif.locked); end
  endtask

  task automatic test_random();
    int countdown;
    int sel;
    logic en, clr, r;
    tick(1'b0, 1'b0, 1'b1);
    countdown = 1;
    for (int c = 0; c < 4000; c++) begin
      en  = (countdown == 1);
      clr = ($urandom_range(0, 49) == 0);
      r   = ($urandom_range(0, 599) == 0);
      if (en) begin
        sel = $urandom_range(0, 9);
        if (sel <= 5)      countdown = DIV;
        else if (sel == 6) countdown = $urandom_range(1, DIV - 1);
        else if (sel == 7) countdown = DIV + 1;
        else if (sel == 8) countdown = $urandom_range(1, TMO + 4);
        else               countdown = TMO;
      end else begin
        countdown--;
      end
      tick(en, clr, r);
      checks++; if (mif.locked !== m_locked[0]) begin errors++; $display("FAIL rand_locked c=%0d: got %0b expected %0d", c, mif.locked, m_locked); end
      checks++; if (mif.err_pulse !== m_err[0]) begin errors++; $display("FAIL rand_err_pulse c=%0d: got %0b expected %0d", c, mif.err_pulse, m_err); end
      checks++; if (mif.period !== CW'(m_period)) begin errors++; $display("FAIL rand_period c=%0d: got %0d expected %0d", c, mif.period, m_period); end
      checks++; if (mif.err_cnt !== 8'(m_errcnt)) begin errors++; $display("FAIL rand_err_cnt c=%0d: got %0d expected %0d", c, mif.err_cnt, m_errcnt); end
    end
  endtask

  task automatic tick1(input logic en, input logic r);
    mif1.en_in = en;
    rst1 = r;
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe1_after(input int n);
    repeat (n - 1) tick1(1'b0, 1'b0);
    tick1(1'b1, 1'b0);
  endtask

  task automatic test_lock_cnt1();
    tick1(1'b0, 1'b1);
    tick1(1'b1, 1'b0);
    strobe1_after(DIV);
    checks++; if (mif1.locked !== 1'b1) begin errors++; $display("FAIL lc1_first_lock: got %0b expected 1", mif1.locked); end
    for (int k = 0; k < 3; k++) begin
      strobe1_after(DIV - 1);
      checks++; if (mif1.err_pulse !== 1'b1 || mif1.locked !== 1'b0) begin errors++; $display("FAIL lc1_drop_%0d: got err=%0b locked=%0b expected 1/0", k, mif1.err_pulse, mif1.locked); end
      checks++; if (mif1.period !== CW'(DIV - 1)) begin errors++; $display("FAIL lc1_short_period_%0d: got %0d expected %0d", k, mif1.period, DIV - 1); end
      strobe1_after(DIV);
      checks++; if (mif1.locked !== 1'b1 || mif1.err_pulse !== 1'b0) begin errors++; $display("FAIL lc1_relock_%0d: got locked=%0b err=%0b expected 1/0", k, mif1.locked, mif1.err_pulse); end
    end
    checks++; if (mif1.err_cnt !== 8'd3) begin errors++; $display("FAIL lc1_err_cnt: got %0d expected 3", mif1.err_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    now_cyc = 0;
    last_strobe = 0;
    m_mode = 0; m_good = 0; m_locked = 0; m_err = 0; m_period = 0; m_errcnt = 0;
    rst = 1'b1;
    rst1 = 1'b1;
    mif.en_in = 1'b0;
    mif.clear = 1'b0;
    mif1.en_in = 1'b0;
    mif1.clear = 1'b0;
    test_reset();
    test_lock();
    test_early();
    test_late();
    test_err_saturation();
    test_reset_mid_lock();
    test_random();
    test_lock_cnt1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/en_period_monitor.md
EN_PERIOD_MONITOR -- requirements
Module: en_period_monitor

Interface
REQ-001 SHALL have parameter DIV, default 16, meaning the expected en_in period in clock cycles; legal values are 2 and above.
REQ-002 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive correct intervals needed to lock; legal values are 1 and above.
REQ-003 SHALL have local constant TMO = 2*DIV and CW = clog2(TMO+1).
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en_in, input, 1 bit: the periodic one-cycle enable strobe under observation.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of err_cnt only.
REQ-008 SHALL have port locked, output, 1 bit: high while the period is verified.
REQ-009 SHALL have port err_pulse, output, 1 bit: a one-cycle strobe on each lock-loss event.
REQ-010 SHALL have port period, output, CW bits: the last measured interval.
REQ-011 SHALL have port err_cnt, output, 8 bits: a saturating count of error events.

Function
REQ-012 SHALL contain interval counter cnt (CW bits): set to 1 on a cycle with en_in high; otherwise increments, saturating at TMO.
REQ-013 SHALL define interval as the cycles between consecutive en_in highs; strobes at cycles t and t+16 measure 16.
REQ-014 SHALL implement the FSM states IDLE, MEASURE and LOCKED; all outputs are registered.
REQ-015 SHALL, in IDLE, ignore cnt; the first en_in moves to MEASURE with good=0 and does not update period.
REQ-016 SHALL, in MEASURE or LOCKED, load period with cnt on every en_in.
REQ-017 SHALL, in MEASURE, on en_in with cnt==DIV, increment good; when good reaches LOCK_CNT, move to LOCKED, with locked high the following cycle.
REQ-018 SHALL, in MEASURE, on en_in with cnt!=DIV, clear good, stay in MEASURE and raise no error.
REQ-019 SHALL, in LOCKED, on en_in with cnt<DIV (early), assert err_pulse and move to MEASURE with good=0.
REQ-020 SHALL, in LOCKED, when cnt==DIV+1 with en_in low (late/missing), assert err_pulse and move to MEASURE with good=0; a later en_in still updates period.
REQ-021 SHALL, in MEASURE, when cnt==TMO with en_in low, return to IDLE with good=0 and no error.
REQ-022 SHALL give en_in precedence over any timeout or late condition evaluated in the same cycle.
REQ-023 SHALL make locked track the LOCKED state registered (1 cycle after the transition cycle), and assert err_pulse exactly one cycle per event.
REQ-024 SHALL increment err_cnt with each err_pulse, saturating at 255.
REQ-025 SHALL give clear precedence over a simultaneous increment, so err_cnt becomes 0.
REQ-026 SHALL count good in clog2(LOCK_CNT+1) bits without overflow.

Reset
REQ-027 SHALL, on rst high at a clk_in edge, set state=IDLE, cnt=0, good=0, locked=0, err_pulse=0, period=0 and err_cnt=0.
REQ-028 SHALL give rst precedence over en_in and clear; reset mid-lock drops locked on the next cycle without err_pulse.

Structure
REQ-029 SHALL place the FSM state encoding and the clog2 function in the shared platform package.
REQ-030 SHALL implement cnt as sub-module en_interval_counter (ports: clk_in, rst, en_in, cnt), instantiated once.
REQ-031 SHALL be synthesizable with no latches and no derived clocks.

Verification
REQ-032 SHALL cover, with DIV=16 and LOCK_CNT=4, en_in every 16 cycles for 5 strobes: locked rises 1 cycle after the 5th strobe, period=16, err_cnt=0.
REQ-033 SHALL cover, once locked, a next strobe after 12 cycles: err_pulse high 1 cycle, locked=0, period=12, err_cnt=1.
REQ-034 SHALL cover, once locked, no further strobe: err_pulse at cnt=17, locked=0, and IDLE reached at cnt=32.
REQ-035 SHALL cover 300 forced errors: err_cnt saturates at 255; clear coincident with an error results in err_cnt=0.
REQ-036 SHALL cover rst asserted for 1 cycle while locked: all outputs 0 next cycle; relock after 5 correct strobes.
REQ-037 SHALL cover LOCK_CNT=1 with alternating 16/15 intervals: locked toggles, and each 15 interval produces an err_pulse.
